// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: boots a program over a valid/ready stream, then
// owns the PC, applying stalls and branches until a halt opcode or program end.
module imem_fetch_ctrl #(
    parameter int unsigned SIZE_IM     = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ready,
    output logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic              load_err,
    output logic [ADDR_W-1:0] prog_len,
    output logic [15:0]       inst_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE_IM - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] wptr, wptr_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] prog_len_d;
    logic [CNT_W-1:0]  inst_cnt_d;
    logic              load_err_d;
    logic              is_halt_op;
    logic [CNT_W-1:0]  cnt_inc;

    // Only the opcode field of the fetched word matters here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[DATA_W-5:0];

    assign is_halt_op = (instr_in[DATA_W-1 -: 4] == HALT_OPCODE);
    assign cnt_inc    = (inst_cnt == CNT_MAX) ? inst_cnt : inst_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            pc       <= '0;
            prog_len <= '0;
            inst_cnt <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_d;
            wptr     <= wptr_d;
            pc       <= pc_d;
            prog_len <= prog_len_d;
            inst_cnt <= inst_cnt_d;
            load_err <= load_err_d;
        end
    end

    // Next-state, counter updates and the combinational memory write port.
    always_comb begin
        state_d    = state;
        wptr_d     = wptr;
        pc_d       = pc;
        prog_len_d = prog_len;
        inst_cnt_d = inst_cnt;
        load_err_d = load_err;
        ld_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        ready      = 1'b0;
        halted     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    wptr_d     = '0;
                    prog_len_d = '0;
                    load_err_d = 1'b0;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = wptr;
                    mem_wdata  = ld_data;
                    wptr_d     = wptr + ADDR_W'(1);
                    prog_len_d = wptr + ADDR_W'(1);
                    if (ld_last || (wptr == LAST_ADDR)) begin
                        state_d    = RUN;
                        pc_d       = '0;
                        inst_cnt_d = '0;
                        load_err_d = !ld_last;
                    end
                end
            end
            RUN: begin
                ready = 1'b1;
                if (is_halt_op || (pc >= prog_len)) begin
                    state_d = HALT;
                end else if (stall) begin
                    pc_d = pc;
                end else if (branch_en) begin
                    pc_d       = branch_target;
                    inst_cnt_d = cnt_inc;
                end else begin
                    pc_d       = pc + ADDR_W'(1);
                    inst_cnt_d = cnt_inc;
                end
            end
            HALT: begin
                ready  = 1'b1;
                halted = 1'b1;
                if (start) begin
                    state_d    = LOAD;
                    wptr_d     = '0;
                    prog_len_d = '0;
                    load_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
